oets_index_sort_ctrl: RTL
=========================

Name: oets_index_sort_ctrl

Overview:
- Sequencer for an odd-even transposition sort over N_INPUTS keys; produces the sorted index permutation rather than sorted data.
- Captures one key vector and sort direction per job, then runs N_INPUTS compare-exchange phases, one phase per cycle, alternating even/odd lane pairing.
- Presents the final index vector on a valid/ready output port.
- Sits in front of the MDSA index datapath as the job-level scheduler for the index compare-exchange stages.

Parameters:
- DATA_WIDTH, 32: key width, unsigned.
- N_INPUTS, 8: lanes per job; must be even and >= 2.
- INDEX_WIDTH, $clog2(N_INPUTS): width of one index lane.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  job offered.
- in_ready  output  1  high only in IDLE.
- in_data  input  DATA_WIDTH*N_INPUTS  keys; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_dir  input  1  1 = ascending, 0 = descending; sampled with the job.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_index  output  INDEX_WIDTH*N_INPUTS  lane k = original index of the k-th sorted key.
- busy  output  1  high in SORT or DONE.

Behaviour:
- Reset: state IDLE, out_valid=0, busy=0, out_index=0, all internal key/index/phase registers=0. in_ready=1 after reset (decoded from IDLE).
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture keys into the lane registers, set index lane k=k, latch in_dir, clear the phase counter, go to SORT.
- State SORT:
  - One phase per edge. Phase counter p is $clog2(N_INPUTS+1) bits and counts 0..N_INPUTS-1.
  - p even: compare-exchange lane pairs (0,1),(2,3),...,(N-2,N-1).
  - p odd: compare-exchange pairs (1,2),...,(N-3,N-2). Lanes 0 and N-1 hold.
  - Compare-exchange on a pair (a = lower lane, b = upper lane): key and index move together.
    - Ascending: swap iff key_a > key_b.
    - Descending: swap iff key_a < key_b.
    - Equal keys never swap, so ordering is stable: tied keys keep their original index order.
  - On the edge that executes phase N_INPUTS-1: go to DONE, load out_index from the index lanes, set out_valid=1.
- Latency: job accepted at edge T; out_valid is high after edge T+N_INPUTS, i.e. N_INPUTS+1 edges from acceptance to result, inclusive of the capture edge.
- State DONE:
  - out_valid=1; out_index held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. in_ready rises the cycle after the handshake. No same-cycle output-to-input bypass.
- in_valid is ignored in SORT and DONE; the offered job is not consumed and is not lost at the source.
- out_ready outside DONE has no effect.
- out_index retains the last result after the handshake; only out_valid qualifies it.
- Reset mid-SORT or mid-DONE: job discarded, all outputs return to reset values immediately (asynchronous).
- Keys compare as unsigned DATA_WIDTH values. No arithmetic widening.

Optional Feature:
- Macro: OETS_EARLY_EXIT_EN.
- Defined:
  - A swap flag records whether any pair swapped in the current phase; a registered copy holds the previous phase's flag.
  - If two consecutive phases (p >= 1) both perform zero swaps, the block enters DONE on that edge with out_valid=1, skipping the remaining phases.
  - Latency becomes data-dependent: minimum 2 phases, maximum N_INPUTS.
- Undefined: always exactly N_INPUTS phases; swap-flag logic is absent.

Test Plan:
1. Reset with rst=1 -> out_valid=0, busy=0, in_ready=1, out_index=0. Release rst -> same values, no spurious output.
2. N_INPUTS=8, keys lane0..7 = 50,10,70,30,20,80,60,40, in_dir=1 -> out_index lane0..7 = 1,4,3,7,0,6,2,5; out_valid rises exactly 8 edges after the accept edge.
3. Same keys, in_dir=0 -> out_index = 5,2,6,0,7,3,4,1.
4. All keys = 5, both directions -> out_index = 0,1,2,3,4,5,6,7 (stable ordering, no swaps).
5. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 held -> out_index stable, in_ready=0, no second job accepted. Then out_ready=1 -> out_valid=0 next cycle, in_ready=1, second job accepted on the following edge.
6. Reset and early exit:
   - Assert rst during phase 3 -> IDLE with zeroed outputs; a new job then sorts correctly.
   - With OETS_EARLY_EXIT_EN, already-ascending keys 1..8 and in_dir=1 -> out_valid after 2 phases, out_index = identity.

Source files
------------

// File: rtl/oets_index_sort_ctrl_if.sv
// Job/result handshake bundle for oets_index_sort_ctrl.
interface oets_index_sort_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int N_INPUTS    = 8,
    parameter int INDEX_WIDTH = $clog2(N_INPUTS)
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH*N_INPUTS-1:0]  in_data;
    logic                            in_dir;
    logic                            out_valid;
    logic                            out_ready;
    logic [INDEX_WIDTH*N_INPUTS-1:0] out_index;
    logic                            busy;

    modport master (
        output in_valid, in_data, in_dir, out_ready,
        input  in_ready, out_valid, out_index, busy
    );

    modport slave (
        input  in_valid, in_data, in_dir, out_ready,
        output in_ready, out_valid, out_index, busy
    );
endinterface

// File: rtl/oets_index_sort_ctrl.sv
// Odd-even transposition sort sequencer producing the sorted index permutation.
// Optional OETS_EARLY_EXIT_EN: finish after two consecutive swap-free phases.
module oets_index_sort_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int N_INPUTS    = 8,
    parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
    input logic                   clk,
    input logic                   rst,
    oets_index_sort_ctrl_if.slave bus
);
    localparam int PW = $clog2(N_INPUTS + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t                          state_q;
    logic [DATA_WIDTH-1:0]           key_q  [N_INPUTS];
    logic [INDEX_WIDTH-1:0]          idx_q  [N_INPUTS];
    logic [DATA_WIDTH-1:0]           key_nx [N_INPUTS];
    logic [INDEX_WIDTH-1:0]          idx_nx [N_INPUTS];
    logic [PW-1:0]                   phase_q;
    logic                            dir_q;
    logic                            out_valid_q;
    logic [INDEX_WIDTH*N_INPUTS-1:0] out_index_q;
    logic                            finish;
`ifdef OETS_EARLY_EXIT_EN
    logic                            swapped;
    logic                            swap_prev_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;

    // Pairs start at lanes whose parity matches the phase parity; pairs are disjoint.
    always_comb begin
        key_nx = key_q;
        idx_nx = idx_q;
`ifdef OETS_EARLY_EXIT_EN
        swapped = 1'b0;
`endif
        for (int unsigned k = 0; k + 1 < N_INPUTS; k++) begin
            if (k[0] == phase_q[0]) begin
                if (dir_q ? (key_q[k] > key_q[k+1]) : (key_q[k] < key_q[k+1])) begin
                    key_nx[k]   = key_q[k+1];
                    key_nx[k+1] = key_q[k];
                    idx_nx[k]   = idx_q[k+1];
                    idx_nx[k+1] = idx_q[k];
`ifdef OETS_EARLY_EXIT_EN
                    swapped = 1'b1;
`endif
                end
            end
        end
    end

`ifdef OETS_EARLY_EXIT_EN
    assign finish = (phase_q == LAST_PHASE) ||
                    ((phase_q != '0) && !swapped && !swap_prev_q);
`else
    assign finish = (phase_q == LAST_PHASE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '{default: '0};
            idx_q       <= '{default: '0};
            phase_q     <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
`ifdef OETS_EARLY_EXIT_EN
            swap_prev_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int unsigned k = 0; k < N_INPUTS; k++) begin
                            key_q[k] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
                            idx_q[k] <= INDEX_WIDTH'(k);
                        end
                        dir_q   <= bus.in_dir;
                        phase_q <= '0;
`ifdef OETS_EARLY_EXIT_EN
                        swap_prev_q <= 1'b0;
`endif
                        state_q <= SORT;
                    end
                end
                SORT: begin
                    key_q   <= key_nx;
                    idx_q   <= idx_nx;
                    phase_q <= phase_q + 1'b1;
`ifdef OETS_EARLY_EXIT_EN
                    swap_prev_q <= swapped;
`endif
                    if (finish) begin
                        // Result is the post-exchange lanes of this final phase.
                        for (int unsigned k = 0; k < N_INPUTS; k++)
                            out_index_q[k*INDEX_WIDTH +: INDEX_WIDTH] <= idx_nx[k];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
